// File: rtl/dfe_pam4_receiver.sv
// Purpose: 1-tap decision-feedback equalizer and slicer for PAM-4 samples, with sign-sign LMS tap training.
// Latency: 1 cycle from a valid sample to the registered symbol/eq outputs; the decision loop closes in one cycle.
// Backpressure: none; one sample is accepted whenever i_signal_in_valid is high, and idle cycles hold all state.
module dfe_pam4_receiver #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int TAP_FRAC_BITS     = 8,
  parameter int H1_INIT           = 0,
  parameter int ADAPT_LENGTH      = 256,
  parameter int MU_STEP           = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0] i_signal_in,
  input  logic                                i_signal_in_valid,
  input  logic                                i_adapt_restart,
  output logic        [1:0]                   o_symbol_out,
  output logic                                o_symbol_out_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] o_eq_out,
  output logic        [TAP_FRAC_BITS-1:0]     o_tap_out,
  output logic                                o_locked
);

  localparam int W  = SIGNAL_RESOLUTION;
  // Two guard bits keep input minus feedback exact for any tap value.
  localparam int EW = W + 2;
  localparam int PW = EW + TAP_FRAC_BITS + 1;
  localparam int CW = (ADAPT_LENGTH > 1) ? $clog2(ADAPT_LENGTH) : 1;

  // Ideal PAM-4 levels, centred on zero.
  localparam logic signed [EW-1:0] LV0   = EW'(-(3 * SYMBOL_SEPERATION) / 2);
  localparam logic signed [EW-1:0] LV1   = EW'(-SYMBOL_SEPERATION / 2);
  localparam logic signed [EW-1:0] LV2   = EW'(SYMBOL_SEPERATION / 2);
  localparam logic signed [EW-1:0] LV3   = EW'((3 * SYMBOL_SEPERATION) / 2);
  localparam logic signed [EW-1:0] SEP_P = EW'(SYMBOL_SEPERATION);
  localparam logic signed [EW-1:0] SEP_N = EW'(-SYMBOL_SEPERATION);

  // Symmetric saturation limits for the equalized output.
  localparam logic signed [EW-1:0] EQ_MAX_E = EW'((1 << (W - 1)) - 1);
  localparam logic signed [EW-1:0] EQ_MIN_E = EW'(-((1 << (W - 1)) - 1));
  localparam logic signed [W-1:0]  EQ_MAX_W = W'((1 << (W - 1)) - 1);
  localparam logic signed [W-1:0]  EQ_MIN_W = W'(-((1 << (W - 1)) - 1));

  localparam logic [TAP_FRAC_BITS:0]   TAP_MAX_X = (TAP_FRAC_BITS + 1)'((1 << TAP_FRAC_BITS) - 1);
  localparam logic [TAP_FRAC_BITS:0]   MU_X      = (TAP_FRAC_BITS + 1)'(MU_STEP);
  localparam logic [TAP_FRAC_BITS-1:0] MU_T      = TAP_FRAC_BITS'(MU_STEP);
  localparam logic [CW-1:0]            CNT_LAST  = CW'(ADAPT_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADAPT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic                      r_locked;
  logic [TAP_FRAC_BITS-1:0]  r_tap;
  logic [1:0]                r_dprev;
  logic [1:0]                r_sym;
  logic                      r_sym_vld;
  logic signed [W-1:0]       r_eq;

  logic signed [EW-1:0]      w_lprev;
  logic signed [PW-1:0]      w_tap_ext;
  logic signed [PW-1:0]      w_lprev_ext;
  logic signed [PW-1:0]      w_prod;
  logic signed [EW-1:0]      w_fb;
  logic signed [EW-1:0]      w_sig_ext;
  logic signed [EW-1:0]      w_eq;
  logic [1:0]                w_dec;
  logic signed [EW-1:0]      w_ldec;
  logic signed [EW:0]        w_err;
  logic                      w_tap_inc;
  logic                      w_tap_dec;
  logic [TAP_FRAC_BITS:0]    w_tap_sum;
  logic [TAP_FRAC_BITS-1:0]  w_tap_up;
  logic [TAP_FRAC_BITS-1:0]  w_tap_dn;
  logic signed [W-1:0]       w_eq_sat;
  logic                      w_adapt_now;

  function automatic logic signed [EW-1:0] f_level(input logic [1:0] s);
    case (s)
      2'd0:    f_level = LV0;
      2'd1:    f_level = LV1;
      2'd2:    f_level = LV2;
      default: f_level = LV3;
    endcase
  endfunction

  // Feedback term: signed tap*level product, arithmetic shift floors toward -inf.
  assign w_lprev     = f_level(r_dprev);
  assign w_tap_ext   = PW'({1'b0, r_tap});
  assign w_lprev_ext = PW'(w_lprev);
  assign w_prod      = w_tap_ext * w_lprev_ext;
  assign w_fb        = EW'(w_prod >>> TAP_FRAC_BITS);
  assign w_sig_ext   = EW'(i_signal_in);
  assign w_eq        = w_sig_ext - w_fb;

  // Slicer: thresholds at -SEP, 0, +SEP.
  always_comb begin
    w_dec = 2'd0;
    if (w_eq < SEP_N)       w_dec = 2'd0;
    else if (w_eq < 0)      w_dec = 2'd1;
    else if (w_eq < SEP_P)  w_dec = 2'd2;
    else                    w_dec = 2'd3;
  end

  // Slicer error against the chosen ideal level drives the sign-sign update.
  assign w_ldec    = f_level(w_dec);
  assign w_err     = EW'(w_eq) - EW'(w_ldec) + (EW + 1)'(0);
  assign w_tap_inc = (w_err != '0) && (w_err[EW] == w_lprev[EW-1]);
  assign w_tap_dec = (w_err != '0) && (w_err[EW] != w_lprev[EW-1]);

  // Saturating tap step in both directions; the tap never wraps.
  assign w_tap_sum = {1'b0, r_tap} + MU_X;
  assign w_tap_up  = (w_tap_sum > TAP_MAX_X) ? TAP_MAX_X[TAP_FRAC_BITS-1:0] : w_tap_sum[TAP_FRAC_BITS-1:0];
  assign w_tap_dn  = (r_tap < MU_T) ? '0 : (r_tap - MU_T);

  // Clip the equalized value to the symmetric output range.
  always_comb begin
    w_eq_sat = W'(w_eq);
    if (w_eq > EQ_MAX_E)      w_eq_sat = EQ_MAX_W;
    else if (w_eq < EQ_MIN_E) w_eq_sat = EQ_MIN_W;
  end

  // Adaptation uses the state before any coincident restart takes effect.
  assign w_adapt_now = i_signal_in_valid && (r_state == ST_ADAPT);

  // Output registers and the previous-decision register advance only on valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym     <= 2'd0;
      r_sym_vld <= 1'b0;
      r_eq      <= '0;
      r_dprev   <= 2'd0;
    end else begin
      r_sym_vld <= i_signal_in_valid;
      if (i_signal_in_valid) begin
        r_sym   <= w_dec;
        r_eq    <= w_eq_sat;
        r_dprev <= w_dec;
      end
    end
  end

  // Tap moves by one step per valid training sample, and is frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap <= TAP_FRAC_BITS'(H1_INIT);
    end else if (w_adapt_now) begin
      if (w_tap_inc)      r_tap <= w_tap_up;
      else if (w_tap_dec) r_tap <= w_tap_dn;
    end
  end

  // Training state machine; restart wins over the end-of-training transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_adapt_restart) begin
      r_state  <= ST_ADAPT;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_signal_in_valid) begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ADAPT;
        end
        ST_ADAPT: begin
          if (r_cnt == CNT_LAST) begin
            r_state  <= ST_LOCKED;
            r_cnt    <= '0;
            r_locked <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_LOCKED: begin
          r_locked <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_symbol_out       = r_sym;
  assign o_symbol_out_valid = r_sym_vld;
  assign o_eq_out           = r_eq;
  assign o_tap_out          = r_tap;
  assign o_locked           = r_locked;

endmodule
